// File: rtl/uart_transmit_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_transmit_unit_pkg
//  Brief    : Phase encodings shared with the main controller, UART frame
//             constants and the transmit-unit FSM state type.
//  Revision : 1.0  initial release
// ============================================================================
package uart_transmit_unit_pkg;

  // Main-controller phase encodings (status bus)
  typedef enum logic [1:0] {
    RECEIVE  = 2'b00,
    PROCESS  = 2'b01,
    TRANSMIT = 2'b10,
    ALLDONE  = 2'b11
  } phase_e;

  // 8N1 frame: start + 8 data + stop
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // Transmit-unit sequencing states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_transmit_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_transmit_unit_if
//  Brief    : Phase status, data-RAM read port and serial-side outputs of the
//             transmit unit, bundled for connection to the unit.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_transmit_unit_if #(
  parameter int ADDR_W = 16
);
  logic [1:0]        status;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              uart_tx;
  logic              tx_busy;
  logic              end_transmitting;

  // Transmit unit side
  modport master (
    input  status, mem_rdata,
    output mem_rd_en, mem_addr, uart_tx, tx_busy, end_transmitting
  );

  // Environment side (controller, RAM, pin)
  modport slave (
    output status, mem_rdata,
    input  mem_rd_en, mem_addr, uart_tx, tx_busy, end_transmitting
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_serializer
//  Brief    : 8N1 serializer. A load pulse starts a frame on the next edge;
//             done pulses during the final cycle of the stop bit.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_serializer
  import uart_transmit_unit_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       IDX_STOP = 4'(FRAME_BITS - 1);

  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 bit_end;

  assign bit_end = busy_q && (cnt_q == CNT_LAST);
  assign done_o  = bit_end && (idx_q == IDX_STOP);
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;

  // Bit timing and shifting; line returns high immediately on reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else if (load_i) begin
      shift_q <= data_i;
      tx_q    <= 1'b0;
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else if (busy_q) begin
      if (bit_end) begin
        cnt_q <= '0;
        idx_q <= idx_q + 4'd1;
        if (idx_q == IDX_STOP) begin
          busy_q <= 1'b0;
          tx_q   <= 1'b1;
        end else if (idx_q == IDX_STOP - 4'd1) begin
          tx_q <= 1'b1;
        end else begin
          tx_q    <= shift_q[0];
          shift_q <= shift_q >> 1;
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_transmit_unit.sv
`default_nettype none
// ============================================================================
//  Module   : uart_transmit_unit
//  Brief    : TRANSMIT-phase engine: reads NUM_BYTES bytes from the data RAM
//             and streams them as 8N1 frames, then raises a sticky done flag.
//  Revision : 1.0  initial release
// ============================================================================
module uart_transmit_unit
  import uart_transmit_unit_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 16,
  parameter int NUM_BYTES    = 65536
) (
  input  logic                clock,
  input  logic                reset_n,
  uart_transmit_unit_if.master bus
);

  // Counter is one bit wider than the address so a full 2**ADDR_W transfer
  // terminates without wrapping back to zero.
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(NUM_BYTES);

  tx_state_e         state_q, state_d;
  logic [ADDR_W:0]   byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              tx_busy_q, tx_busy_d;
  logic              end_q, end_d;
  logic              ser_load;
  logic              ser_tx, ser_busy, ser_done;

  assign bus.mem_rd_en        = mem_rd_en_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.tx_busy          = tx_busy_q;
  assign bus.end_transmitting = end_q;
  assign bus.uart_tx          = ser_tx;

  // State, counter and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      tx_busy_q   <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
      tx_busy_q   <= tx_busy_d;
      end_q       <= end_d;
    end
  end

  // Next state; outputs are decoded from the next state so they are valid
  // in the same cycle the FSM enters the corresponding state.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    ser_load   = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.status == TRANSMIT) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        // RAM data is valid now; the serializer has already gone idle
        if (!ser_busy) begin
          ser_load = 1'b1;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (ser_done) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          state_d    = (byte_cnt_d == LAST_CNT) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    mem_rd_en_d = (state_d == S_FETCH);
    mem_addr_d  = (state_d == S_FETCH) ? byte_cnt_d[ADDR_W-1:0] : mem_addr_q;
    tx_busy_d   = state_d inside {S_FETCH, S_WAIT, S_SEND};
    end_d       = (state_d == S_DONE);
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_ser (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (ser_load),
    .data_i  (bus.mem_rdata),
    .tx_o    (ser_tx),
    .busy_o  (ser_busy),
    .done_o  (ser_done)
  );

endmodule
`default_nettype wire
